// File: rtl/pe_result_drain_if.sv
// rtl/pe_result_drain_if.sv - result stream interface between the PE result drain and its consumer
//
// Parameters: W result width, ROWS/COLS array shape (sets index widths).
// Signals:
//   res_data  [W]   current result word
//   res_valid       data, indices and last flag are valid
//   res_ready       consumer accepts the word this cycle
//   res_row   [RW]  row index of res_data
//   res_col   [CW]  column index of res_data
//   res_last        final word of a tile
// Modports: master (drain side), slave (consumer side).

interface pe_result_drain_if #(
  parameter int W    = 17,
  parameter int ROWS = 2,
  parameter int COLS = 2
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [W-1:0]  res_data;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic          res_last;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready,
    output res_row,
    output res_col,
    output res_last
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready,
    input  res_row,
    input  res_col,
    input  res_last
  );
endinterface

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - snapshots all PE results on completion and streams them out row-major
//
// Parameters: N MAC depth (result width W = N+15), ROWS, COLS array shape.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   pe_out      flattened PE results, PE (r,c) at k = r*COLS+c, bits [k*W +: W]
//   pe_done     per-PE done flags, same index k
//   res         result stream (master modport of pe_result_drain_if)
//   busy        a snapshot is held and not yet fully drained
//   drain_done  one-cycle pulse after the last word transfers
//   overrun     sticky: a new completion arrived while draining
//   clear_err   synchronous clear of overrun

module pe_result_drain #(
  parameter int N    = 2,
  parameter int ROWS = 2,
  parameter int COLS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS*COLS*(N+15)-1:0]    pe_out,
  input  logic [ROWS*COLS-1:0]           pe_done,
  pe_result_drain_if.master              res,
  output logic                           busy,
  output logic                           drain_done,
  output logic                           overrun,
  input  logic                           clear_err
);
  localparam int W  = N + 15;
  localparam int NW = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          all_done, all_done_q, start, at_last;
  logic          capture, advance, finish;
  logic [W-1:0]  snap [NW];
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  // Linear word index kept alongside row/col so the bank is addressed without a multiply.
  logic [KW-1:0] idx;

  assign all_done = &pe_done;
  assign start    = all_done & ~all_done_q;
  assign at_last  = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
          capture   = 1'b1;
        end
      end
      DRAIN: begin
        if (res.res_ready) begin
          if (at_last) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Resets high so a done vector already high when reset lifts is not mistaken for a new tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) all_done_q <= 1'b1;
    else     all_done_q <= all_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (capture || finish) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (advance) begin
      idx <= idx + KW'(1);
      if (col == COL_MAX) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) snap[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NW; k++) snap[k] <= pe_out[k*W +: W];
    end
  end

  // A completion during DRAIN only flags the error; the held snapshot is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      drain_done <= finish;
      if (start && (state == DRAIN)) overrun <= 1'b1;
      else if (clear_err)            overrun <= 1'b0;
    end
  end

  assign busy          = (state == DRAIN);
  assign res.res_valid = (state == DRAIN);
  assign res.res_data  = (state == DRAIN) ? snap[idx] : '0;
  assign res.res_row   = row;
  assign res.res_col   = col;
  assign res.res_last  = (state == DRAIN) && at_last;

endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - randomized self-checking bench for pe_result_drain against a tile-level model

module tb_pe_result_drain;
  localparam int N    = 2;
  localparam int W    = N + 15;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int NW   = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst;
  logic [NW*W-1:0] pe_out;
  logic [NW-1:0]   pe_done;
  logic            clear_err;
  logic            busy, drain_done, overrun;

  pe_result_drain_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) res_if ();

  pe_result_drain #(.N(N), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .pe_out     (pe_out),
    .pe_done    (pe_done),
    .res        (res_if),
    .busy       (busy),
    .drain_done (drain_done),
    .overrun    (overrun),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dut_xfers = 0;
  int n_dut_done  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Tile-level model: a captured list of words and a position within it.
  bit           m_busy, m_overrun, m_done, m_prev_all;
  int           m_pos;
  logic [W-1:0] m_words [NW];

  task automatic model_reset();
    m_busy     = 0;
    m_overrun  = 0;
    m_done     = 0;
    m_prev_all = 1;
    m_pos      = 0;
    for (int k = 0; k < NW; k++) m_words[k] = '0;
  endtask

  task automatic model_step();
    bit all_now, start, xfer;
    if (rst) begin
      model_reset();
      return;
    end
    all_now = &pe_done;
    start   = all_now && !m_prev_all;
    xfer    = m_busy && res_if.res_ready;
    m_done  = xfer && (m_pos == NW - 1);
    if (start && m_busy)  m_overrun = 1;
    else if (clear_err)   m_overrun = 0;
    if (!m_busy && start) begin
      for (int k = 0; k < NW; k++) m_words[k] = pe_out[k*W +: W];
      m_pos  = 0;
      m_busy = 1;
    end else if (xfer) begin
      m_pos++;
      if (m_pos == NW) begin
        m_busy = 0;
        m_pos  = 0;
      end
    end
    m_prev_all = all_now;
  endtask

  task automatic compare_outputs();
    check("res_valid", 32'(res_if.res_valid), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("drain_done", 32'(drain_done), 32'(m_done));
    check("overrun", 32'(overrun), 32'(m_overrun));
    if (m_busy) begin
      check("res_data", 32'(res_if.res_data), 32'(m_words[m_pos]));
      check("res_row", 32'(res_if.res_row), 32'(m_pos / COLS));
      check("res_col", 32'(res_if.res_col), 32'(m_pos % COLS));
      check("res_last", 32'(res_if.res_last), 32'(m_pos == NW - 1));
    end else begin
      check("res_last_idle", 32'(res_if.res_last), 32'd0);
    end
  endtask

  task automatic cycle();
    if (res_if.res_valid && res_if.res_ready) n_dut_xfers++;
    model_step();
    @(posedge clk);
    #1;
    if (drain_done) n_dut_done++;
    compare_outputs();
  endtask

  task automatic set_tile(input int a, input int b, input int c, input int d);
    pe_out = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  task automatic raise_done();
    pe_done = '0;
    cycle();
    pe_done = '1;
  endtask

  int x0, d0;
  bit ready_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst = 1'b1;
    pe_done = '1;
    pe_out = '0;
    clear_err = 1'b0;
    res_if.res_ready = 1'b0;
    model_reset();
    #1;
    // Reset held with done high, then released: nothing may start.
    repeat (3) cycle();
    check("rst_data", 32'(res_if.res_data), 32'd0);
    check("rst_row", 32'(res_if.res_row), 32'd0);
    check("rst_col", 32'(res_if.res_col), 32'd0);
    rst = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (5) cycle();
    check("idle_no_valid", 32'(res_if.res_valid), 32'd0);

    // Basic drain at full throughput.
    set_tile(100, 200, 300, 400);
    x0 = n_dut_xfers; d0 = n_dut_done;
    raise_done();
    repeat (7) cycle();
    check("basic_xfers", 32'(n_dut_xfers - x0), 32'd4);
    check("basic_done_pulses", 32'(n_dut_done - d0), 32'd1);

    // Backpressure pattern.
    x0 = n_dut_xfers;
    raise_done();
    cycle();
    for (int i = 0; i < 7; i++) begin
      res_if.res_ready = ready_pat[i];
      cycle();
    end
    res_if.res_ready = 1'b1;
    repeat (3) cycle();
    check("bp_xfers", 32'(n_dut_xfers - x0), 32'd4);

    // Input changes after capture must not reach the drained words.
    raise_done();
    cycle();
    pe_out = '1;
    repeat (6) cycle();
    set_tile(100, 200, 300, 400);

    // Overrun during a stalled drain.
    res_if.res_ready = 1'b0;
    raise_done();
    cycle();
    cycle();
    pe_out = {$urandom, $urandom, $urandom};
    pe_done = '0;
    cycle();
    pe_done = '1;
    repeat (3) cycle();
    check("overrun_set", 32'(overrun), 32'd1);
    res_if.res_ready = 1'b1;
    repeat (6) cycle();
    check("overrun_sticky", 32'(overrun), 32'd1);
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a drain.
    set_tile(100, 200, 300, 400);
    raise_done();
    cycle();
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_valid", 32'(res_if.res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_row", 32'(res_if.res_row), 32'd0);
    check("mid_rst_col", 32'(res_if.res_col), 32'd0);
    cycle();
    check("mid_rst_no_done", 32'(drain_done), 32'd0);
    rst = 1'b0;
    cycle();
    raise_done();
    repeat (6) cycle();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      pe_out = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 5) == 0) pe_done = (&pe_done) ? NW'($urandom_range(0, 14)) : '1;
      res_if.res_ready = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Output-side companion to the systolic PE array; consumes what the processing elements produce.
- Watches the per-PE accumulator results and their PDONE flags.
- When every PE has finished, snapshots all results into a local register bank in one cycle.
- Then streams the results out one per transfer, row-major, over a valid/ready interface toward the result buffer or host, freeing the array for the next tile.

Parameters:
- N, 2: accumulation depth of each PE's MAC; sets result width W = N+15 bits, identical to the PE output width.
- ROWS, 2: PE array rows (>=1).
- COLS, 2: PE array columns (>=1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pe_out  input  ROWS*COLS*W  flattened PE results; PE (r,c) is at index k = r*COLS+c, bits [k*W +: W].
- pe_done  input  ROWS*COLS  PDONE of each PE, same index k.
- res_data  output  W  current result word.
- res_valid  output  1  res_data, res_row, res_col and res_last are valid.
- res_ready  input  1  downstream accepts the word this cycle.
- res_row  output  clog2(ROWS) (min 1)  row index of res_data.
- res_col  output  clog2(COLS) (min 1)  column index of res_data.
- res_last  output  1  high with res_valid on the final word of a tile.
- busy  output  1  high while a snapshot is held and not fully drained.
- drain_done  output  1  one-cycle pulse after the last word transfers.
- overrun  output  1  sticky error flag: a new completion arrived while busy.
- clear_err  input  1  synchronous clear of overrun.

Behaviour:
- Definitions:
  - all_done = AND of pe_done.
  - all_done_q = all_done registered each cycle.
  - start = all_done & ~all_done_q, i.e. the rising edge of all_done.
  - Transfer = res_valid & res_ready at a clock edge.
- Reset (asynchronous, immediate):
  - State goes to IDLE; row and column counters go to 0; snapshot bank is cleared to 0.
  - res_valid=0, res_last=0, busy=0, drain_done=0, overrun=0, res_data=0, res_row=0, res_col=0.
  - all_done_q resets to 1. A pe_done vector held high across reset therefore does not trigger a capture; pe_done must fall and rise again.
- IDLE:
  - On an edge with start=1, load all ROWS*COLS words of pe_out into the snapshot bank in that same edge.
  - Clear the counters and move to DRAIN.
- DRAIN:
  - res_valid=1 and busy=1, both decoded from state (first cycle after the capture edge, so latency is 1 cycle from start sampled).
  - res_data = snapshot[row*COLS+col]; res_row and res_col equal the counters.
  - res_last = (row==ROWS-1 and col==COLS-1).
- Handshake:
  - While res_ready=0, data, indices and res_valid hold stable. res_valid never drops before a transfer.
  - On each transfer, col increments. When col wraps from COLS-1 to 0, row increments. Counters are used, never a divider.
  - On a transfer with res_last=1, state returns to IDLE and drain_done is registered high for exactly the next cycle.
- Back-to-back tiles:
  - A start on the same edge as the last transfer is an overrun. It is not captured, because the capture decision is made only in IDLE.
  - A start on the first edge in IDLE is captured normally.
- Overrun:
  - Set on any edge with start=1 while the state is DRAIN.
  - The in-progress snapshot is not disturbed.
  - Cleared only by clear_err=1 at an edge. If set and clear occur on the same edge, set wins.
- Other rules:
  - pe_out changes after capture have no effect on the words being drained.
  - Degenerate ROWS=COLS=1: a single word with res_last=1; drain_done follows its transfer.
  - No arithmetic is performed; results pass through bit-exact at W bits.

Test Plan:
1. Reset then idle: hold rst=1, pe_done=4'b1111 with ROWS=COLS=2 and N=2 (W=17), then release rst. Required: no res_valid while pe_done stays high; outputs all 0.
2. Basic drain: pe_out = {17'd400, 17'd300, 17'd200, 17'd100}; pe_done goes 0000 -> 1111; res_ready=1. Required:
   - res_valid one cycle after the start edge.
   - Words 100, 200, 300, 400 on consecutive cycles with (row,col) = (0,0), (0,1), (1,0), (1,1).
   - res_last only on 400.
   - drain_done pulse on the following cycle; busy low afterwards.
3. Backpressure: as scenario 2, but res_ready toggles 1,0,0,1,0,1,1. Required: each word held stable while ready=0; 4 transfers total; order unchanged.
4. Snapshot isolation: change pe_out to all 17'h1FFFF one cycle after capture. Required: the drained values remain 100..400.
5. Overrun: during a drain stalled with res_ready=0, drop pe_done to 0000 then raise it to 1111. Required:
   - overrun=1 and stays set.
   - The current drain completes with the original data.
   - clear_err=1 clears overrun.
6. Reset mid-drain: assert rst after 2 transfers. Required: res_valid, busy and the counters drop to 0 immediately; no drain_done pulse; the next 0000 -> 1111 edge starts a fresh drain from (0,0).
